// File: rtl/score_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : score_disp_pkg
//  Purpose  : Shared constants for the score display scanner: active-low
//             7-segment patterns (gfedcba), default digit count and the
//             "all off" values driven on the anode/segment pins.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package score_disp_pkg;

  localparam int DEFAULT_DIGITS = 4;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Pin values with everything switched off (active-low outputs)
  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic       AN_OFF_BIT = 1'b1;

endpackage : score_disp_pkg
`default_nettype wire

// File: rtl/bcd_to_seg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_seg
//  Purpose  : Combinational BCD to active-low 7-segment encoder. Codes 10..15
//             display 'E'; the blank flag overrides the code.
//  Ports    : i_bcd   [3:0]  BCD digit
//             i_blank        1 = drive all segments off
//             o_seg   [6:0]  active-low pattern {g,f,e,d,c,b,a}
//  Revision : 1.0  initial release
// ============================================================================
module bcd_to_seg
  import score_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_E;
    if (i_blank) begin
      o_seg = SEG_BLANK;
    end else begin
      case (i_bcd)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_E;
      endcase
    end
  end

endmodule : bcd_to_seg
`default_nettype wire

// File: rtl/score_display_scan.sv
`default_nettype none
// ============================================================================
//  Module   : score_display_scan
//  Purpose  : Time-multiplexed common-anode 7-segment driver for a packed BCD
//             score. The score is snapshotted once per scan frame, leading
//             zeros can be blanked, non-BCD nibbles show 'E', and the display
//             blinks for BLINK_FRAMES frames after the score changes.
//  Ports    : clk                      system clock
//             rst                      asynchronous active-high reset
//             bcd_in      [4*DIGITS-1:0] packed BCD, digit 0 = LS nibble
//             display_en               0 = all anodes off (scan keeps running)
//             blank_en                 1 = leading-zero blanking
//             an          [DIGITS-1:0] anode enables, active-low
//             seg         [7:0]        {dp,g,f,e,d,c,b,a}, active-low
//             frame_pulse              one-cycle pulse at snapshot
//  Revision : 1.0  initial release
// ============================================================================
module score_display_scan
  import score_disp_pkg::*;
#(
  parameter int DIGITS       = DEFAULT_DIGITS,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 6
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  display_en,
  input  logic                  blank_en,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  frame_pulse
);

  localparam int c_PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int c_BLINK_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(SCAN_DIV - 1);
  localparam logic [c_IDX_W-1:0]   c_IDX_LAST   = c_IDX_W'(DIGITS - 1);
  localparam logic [c_BLINK_W-1:0] c_BLINK_LOAD = c_BLINK_W'(BLINK_FRAMES);
  localparam logic [DIGITS-1:0]    c_AN_ONE     = DIGITS'(1);
  localparam logic [DIGITS-1:0]    c_AN_OFF     = {DIGITS{AN_OFF_BIT}};

  logic [c_PRESC_W-1:0] r_presc;
  logic [c_IDX_W-1:0]   r_idx;
  logic [4*DIGITS-1:0]  r_shadow;
  logic [c_BLINK_W-1:0] r_blink_cnt;
  logic                 r_frame_pulse;
  logic [DIGITS-1:0]    r_an;
  logic [7:0]           r_seg;

  logic                 w_tick;
  logic                 w_frame_end;
  logic                 w_dark;
  logic [DIGITS-1:0]    w_zero_from;
  logic                 w_run;
  logic [3:0]           w_cur_digit;
  logic                 w_cur_blank;
  logic [6:0]           w_seg7;

  assign w_tick      = (r_presc == c_PRESC_LAST);
  assign w_frame_end = w_tick && (r_idx == c_IDX_LAST);
  // Odd blink counts are the dark frames; the count is loaded even so the
  // first frame after a change is lit and the final (zero) frame stays lit.
  assign w_dark      = !display_en || r_blink_cnt[0];

  // w_zero_from[i]: shadow digits i..DIGITS-1 are all zero. Built from the
  // most significant digit downwards as a running AND.
  always_comb begin
    w_zero_from = '0;
    w_run       = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_run          = w_run & (r_shadow[4*i +: 4] == 4'd0);
      w_zero_from[i] = w_run;
    end
  end

  // Select the digit for the current scan slot; digit 0 is never blanked.
  always_comb begin
    w_cur_digit = 4'd0;
    w_cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == c_IDX_W'(i)) begin
        w_cur_digit = r_shadow[4*i +: 4];
        w_cur_blank = blank_en && (i != 0) && w_zero_from[i];
      end
    end
  end

  bcd_to_seg u_bcd_to_seg (
    .i_bcd   (w_cur_digit),
    .i_blank (w_cur_blank),
    .o_seg   (w_seg7)
  );

  // Scan timing: prescaler, digit index, snapshot and blink counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc       <= '0;
      r_idx         <= '0;
      r_shadow      <= '0;
      r_blink_cnt   <= '0;
      r_frame_pulse <= 1'b0;
    end else begin
      r_presc       <= w_tick ? '0 : r_presc + 1'b1;
      r_frame_pulse <= w_frame_end;
      if (w_tick) begin
        r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
      end
      if (w_frame_end) begin
        r_shadow <= bcd_in;
        // A fresh change restarts the blink even if one is in progress
        if (bcd_in != r_shadow) begin
          r_blink_cnt <= c_BLINK_LOAD;
        end else if (r_blink_cnt != '0) begin
          r_blink_cnt <= r_blink_cnt - 1'b1;
        end
      end
    end
  end

  // Registered pin drivers, one cycle behind idx/shadow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= c_AN_OFF;
      r_seg <= SEG_OFF;
    end else begin
      r_an  <= w_dark ? c_AN_OFF : ~(c_AN_ONE << r_idx);
      r_seg <= {1'b1, (w_dark ? SEG_BLANK : w_seg7)};
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign frame_pulse = r_frame_pulse;

endmodule : score_display_scan
`default_nettype wire

// File: doc/score_display_scan.md
Name: score_display_scan

Overview:
Reads the packed BCD score word and drives a time-multiplexed common-anode 7-segment display, one digit per scan slot. It snapshots the score once per scan frame so a frame never mixes old and new digits. Leading zeros are blanked, non-BCD nibbles show 'E', and the display blinks for a few frames after the score changes. It sits between the score counter and the board's 7-segment pins.

Parameters:
DIGITS, 4, number of display digits; bcd_in width is 4*DIGITS.
SCAN_DIV, 50000, clock cycles per digit slot; must be >= 2.
BLINK_FRAMES, 6, frames of blink after a score change; must be even and >= 2.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
bcd_in  in  4*DIGITS  packed BCD score; digit i is bcd_in[4i+3:4i]; digit 0 is the least significant.
display_en  in  1  when 0, all anodes are off; scanning continues.
blank_en  in  1  when 1, leading-zero blanking is enabled.
an  out  DIGITS  anode enables, active-low, one-hot-low while lit.
seg  out  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}; dp is always 1.
frame_pulse  out  1  one-cycle pulse when the snapshot is taken.

Behaviour:
- Reset (async, rst=1):
  - presc=0, idx=0, shadow=0, blink_cnt=0.
  - an=all 1, seg=8'hFF, frame_pulse=0.
- Prescaler:
  - presc counts 0..SCAN_DIV-1 and wraps.
  - tick is asserted while presc==SCAN_DIV-1.
- Digit index:
  - On tick, idx <= (idx==DIGITS-1) ? 0 : idx+1.
- Frame boundary: tick && idx==DIGITS-1. On that edge:
  - shadow <= bcd_in.
  - frame_pulse <= 1 for exactly one cycle.
  - If bcd_in != shadow: blink_cnt <= BLINK_FRAMES. A change during an active blink restarts it.
  - Else if blink_cnt != 0: blink_cnt <= blink_cnt-1.
- Digit blanking. Digit i is blank if blank_en=1, i!=0, and shadow digits i..DIGITS-1 are all zero. Digit 0 is never blanked.
- Segment encoding (7-bit gfedcba, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Any value 10..15 = 06 ('E'). Blank = 7F.
- Output register, updated every cycle from the current idx and shadow:
  - dark = !display_en || blink_cnt[0].
  - an <= dark ? all 1 : ~(1<<idx).
  - seg <= {1'b1, dark ? 7F : enc(digit idx)}.
- Latency:
  - an/seg reflect a new idx one cycle after the idx edge.
  - The new shadow first appears on digit 0 one cycle after frame_pulse.
- bcd_in changes mid-frame: not visible until the next frame boundary.
- Reset mid-scan: outputs go dark immediately. Scanning restarts at digit 0 after release.
- The first frame after reset compares against shadow=0. A nonzero score at that frame therefore triggers a blink; this is intended.

Decomposition:
- Package score_disp_pkg holds:
  - the SEG_0..SEG_9, SEG_E and SEG_BLANK 7-bit constants;
  - the DIGITS default;
  - the an/seg off values.
- Sub-module bcd_to_seg: combinational; 4-bit BCD plus blank flag in, 7-bit active-low pattern out. Unit-tested standalone for all 16 codes and for blank.

Test Plan:
1. Reset then idle: DIGITS=4, SCAN_DIV=4, bcd_in=16'h0000, blank_en=1, display_en=1.
   - After the first frame boundary, only an=4'b1110 is ever low, with seg=8'hC0 ('0').
   - The other slots show an=1111 (blanked) or an-low with seg=8'hFF.
   - No blink.
2. Leading-zero blanking: bcd_in=16'h0305, blank_en=1.
   - Slots give seg=92 ('5'), C0 ('0'), B0 ('3') and blank on digits 0..3.
   - With blank_en=0, digit 3 shows C0.
3. Snapshot timing: bcd_in changes 0120->0121 in mid-frame.
   - Digit 0 keeps showing '0' (C0) until frame_pulse.
   - seg=F9 appears on the digit-0 slot one cycle after frame_pulse.
4. Blink: score changes once with BLINK_FRAMES=6.
   - Display is dark on frames with blink_cnt=5, 3, 1 and lit on 6, 4, 2, 0.
   - A second change at blink_cnt=3 reloads 6.
5. Invalid nibble: bcd_in=16'h00A7.
   - Digit 1 shows seg=86 ('E'); digit 0 shows F8 ('7').
   - display_en=0 forces an=1111 while idx keeps advancing.
6. Async reset asserted mid-slot, between clock edges:
   - an=1111, seg=FF, frame_pulse=0 immediately.
   - After release, the first tick occurs SCAN_DIV cycles later with idx 0->1.
